// File: rtl/ddr_wr_fifo_ctrl.sv
// ddr_wr_fifo_ctrl: user write FIFO and burst request sequencer for the SDRAM write controller.
// Ports: sys_clk/sys_rst_n; user_wr_* push side with full/level/overflow/underflow status;
//   wr_base/end/load/burst_len configuration; wr_en/addr/burst_len/data request side;
//   wr_ack/wr_end handshakes from the write controller.
module ddr_wr_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 1024,
    parameter int AW         = 10
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  init_end_i,
    input  logic                  user_wr_en_i,
    input  logic [DATA_WIDTH-1:0] user_wr_data_i,
    output logic                  user_full_o,
    output logic [AW:0]           fifo_level_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    input  logic [23:0]           wr_base_addr_i,
    input  logic [23:0]           wr_end_addr_i,
    input  logic                  wr_addr_load_i,
    input  logic [9:0]            wr_burst_len_i,
    output logic                  wr_en_o,
    output logic [23:0]           wr_addr_o,
    output logic [9:0]            wr_burst_len_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic                  wr_ack_i,
    input  logic                  wr_end_i
);

    typedef enum logic [1:0] {IDLE, REQ, BURST, DONE} state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           level;
    logic [AW:0]           level_nxt;
    logic                  full_q;
    logic                  push;
    logic                  pop;

    state_t      state;
    state_t      state_nxt;
    logic        launch;
    logic        load_pend;
    logic [23:0] nxt_addr;

    assign pop  = wr_ack_i && (level != '0);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push = user_wr_en_i && (!full_q || pop);

    always_comb begin
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + 1'b1;
        else if (pop && !push)
            level_nxt = level - 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (push)
            mem[wr_ptr] <= user_wr_data_i;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            full_q      <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            level  <= level_nxt;
            full_q <= (level_nxt == (AW+1)'(FIFO_DEPTH));
            if (user_wr_en_i && full_q && !pop)
                overflow_o <= 1'b1;
            if (wr_ack_i && level == '0)
                underflow_o <= 1'b1;
        end
    end

    assign user_full_o  = full_q;
    assign fifo_level_o = level;
    // Head word is forced to zero while empty so the reset value is defined.
    assign wr_data_o    = (level != '0) ? mem[rd_ptr] : '0;

    assign launch = init_end_i && (wr_burst_len_i != '0)
                 && (32'(level) >= 32'(wr_burst_len_i));

    assign nxt_addr = wr_addr_o + {14'd0, wr_burst_len_o};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (launch) state_nxt = REQ;
            REQ:     if (wr_ack_i) state_nxt = BURST;
            BURST:   if (wr_end_i) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            wr_en_o        <= 1'b0;
            wr_addr_o      <= '0;
            wr_burst_len_o <= '0;
            load_pend      <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_en_o <= (state_nxt == REQ);
            if (state == IDLE && launch)
                wr_burst_len_o <= wr_burst_len_i;
            // Loads arriving mid-transaction wait for DONE so the
            // address never changes under an active burst.
            if (state == IDLE || state == DONE)
                load_pend <= 1'b0;
            else if (wr_addr_load_i)
                load_pend <= 1'b1;
            if (state == IDLE) begin
                if (wr_addr_load_i)
                    wr_addr_o <= wr_base_addr_i;
            end else if (state == DONE) begin
                if (load_pend || wr_addr_load_i)
                    wr_addr_o <= wr_base_addr_i;
                else if (nxt_addr >= wr_end_addr_i)
                    wr_addr_o <= wr_base_addr_i;
                else
                    wr_addr_o <= nxt_addr;
            end
        end
    end

endmodule

// File: tb/tb_ddr_wr_fifo_ctrl.sv
// tb_ddr_wr_fifo_ctrl: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_ddr_wr_fifo_ctrl;

    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          init_end_i;
    logic          user_wr_en_i;
    logic [DW-1:0] user_wr_data_i;
    logic          user_full_o;
    logic [AW:0]   fifo_level_o;
    logic          overflow_o;
    logic          underflow_o;
    logic [23:0]   wr_base_addr_i;
    logic [23:0]   wr_end_addr_i;
    logic          wr_addr_load_i;
    logic [9:0]    wr_burst_len_i;
    logic          wr_en_o;
    logic [23:0]   wr_addr_o;
    logic [9:0]    wr_burst_len_o;
    logic [DW-1:0] wr_data_o;
    logic          wr_ack_i;
    logic          wr_end_i;

    ddr_wr_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AW(AW)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .init_end_i     (init_end_i),
        .user_wr_en_i   (user_wr_en_i),
        .user_wr_data_i (user_wr_data_i),
        .user_full_o    (user_full_o),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o),
        .wr_base_addr_i (wr_base_addr_i),
        .wr_end_addr_i  (wr_end_addr_i),
        .wr_addr_load_i (wr_addr_load_i),
        .wr_burst_len_i (wr_burst_len_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_burst_len_o (wr_burst_len_o),
        .wr_data_o      (wr_data_o),
        .wr_ack_i       (wr_ack_i),
        .wr_end_i       (wr_end_i)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        push;
        logic [15:0] data;
        logic        ack;
        logic        wend;
        int          lvl;
        logic [15:0] head;
        logic        en;
        logic [23:0] addr;
        logic        unf;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic burst(input int n, input logic [23:0] exp_addr,
                         input bit ld, input logic [23:0] ld_base);
        int w;
        for (int i = 0; i < n; i++) begin
            user_wr_en_i   = 1'b1;
            user_wr_data_i = 16'(16'hB0 + i);
            tick();
        end
        user_wr_en_i = 1'b0;
        w = 0;
        while (!wr_en_o && w < 10) begin
            tick();
            w++;
        end
        chk("burst_req_seen", 32'(wr_en_o), 32'd1);
        chk("burst_req_addr", 32'(wr_addr_o), 32'(exp_addr));
        for (int i = 0; i < n; i++) begin
            wr_ack_i = 1'b1;
            if (ld && i == 1) begin
                wr_addr_load_i = 1'b1;
                wr_base_addr_i = ld_base;
            end
            tick();
            wr_addr_load_i = 1'b0;
        end
        wr_ack_i = 1'b0;
        wr_end_i = 1'b1;
        tick();
        wr_end_i = 1'b0;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q[$];
        logic        m_ovf;
        logic        m_unf;
        logic [23:0] exp_addr;
        logic [9:0]  cur_len;
        logic [9:0]  blen;
        int          cs;
        int          rem;
        int          acked;
        int          waitc;
        logic        p;
        logic        a;
        logic        pp;
        logic        full;
        logic [15:0] d;
        logic [23:0] s;

        sys_rst_n      = 1'b0;
        init_end_i     = 1'b1;
        user_wr_en_i   = 1'b0;
        user_wr_data_i = '0;
        wr_base_addr_i = 24'h0;
        wr_end_addr_i  = 24'h1000;
        wr_addr_load_i = 1'b0;
        wr_burst_len_i = 10'd8;
        wr_ack_i       = 1'b0;
        wr_end_i       = 1'b0;
        tick();
        tick();
        chk("rst_level", 32'(fifo_level_o), 32'd0);
        chk("rst_full", 32'(user_full_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_unf", 32'(underflow_o), 32'd0);
        chk("rst_wr_en", 32'(wr_en_o), 32'd0);
        chk("rst_addr", 32'(wr_addr_o), 32'd0);
        chk("rst_len", 32'(wr_burst_len_o), 32'd0);
        chk("rst_data", 32'(wr_data_o), 32'd0);
        sys_rst_n = 1'b1;
        tick();

        vt.push_back('{1'b0, 16'h0, 1'b1, 1'b0, 0, 16'h0, 1'b0, 24'h0, 1'b1});
        for (int i = 0; i < 7; i++)
            vt.push_back('{1'b1, 16'(16'hA0 + i), 1'b0, 1'b0, i + 1,
                           16'hA0, 1'b0, 24'h0, 1'b1});
        vt.push_back('{1'b0, 16'h0, 1'b0, 1'b0, 7, 16'hA0, 1'b0, 24'h0, 1'b1});
        vt.push_back('{1'b1, 16'hA7, 1'b0, 1'b0, 8, 16'hA0, 1'b0, 24'h0, 1'b1});
        vt.push_back('{1'b0, 16'h0, 1'b0, 1'b0, 8, 16'hA0, 1'b1, 24'h0, 1'b1});
        for (int i = 0; i < 8; i++)
            vt.push_back('{1'b0, 16'h0, 1'b1, 1'b0, 7 - i, 16'(16'hA1 + i),
                           1'b0, 24'h0, 1'b1});
        vt.push_back('{1'b0, 16'h0, 1'b0, 1'b1, 0, 16'h0, 1'b0, 24'h0, 1'b1});
        vt.push_back('{1'b0, 16'h0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 24'h8, 1'b1});

        foreach (vt[k]) begin
            user_wr_en_i   = vt[k].push;
            user_wr_data_i = vt[k].data;
            wr_ack_i       = vt[k].ack;
            wr_end_i       = vt[k].wend;
            tick();
            chk($sformatf("vec%0d_level", k), 32'(fifo_level_o), 32'(vt[k].lvl));
            chk($sformatf("vec%0d_wr_en", k), 32'(wr_en_o), 32'(vt[k].en));
            chk($sformatf("vec%0d_addr", k), 32'(wr_addr_o), 32'(vt[k].addr));
            chk($sformatf("vec%0d_unf", k), 32'(underflow_o), 32'(vt[k].unf));
            if (vt[k].lvl != 0)
                chk($sformatf("vec%0d_head", k), 32'(wr_data_o), 32'(vt[k].head));
        end
        user_wr_en_i = 1'b0;
        wr_ack_i     = 1'b0;
        wr_end_i     = 1'b0;

        wr_base_addr_i = 24'h10;
        wr_end_addr_i  = 24'h20;
        wr_addr_load_i = 1'b1;
        tick();
        wr_addr_load_i = 1'b0;
        chk("load_idle_addr", 32'(wr_addr_o), 32'h10);
        burst(8, 24'h10, 1'b0, 24'h0);
        chk("wrap_addr1", 32'(wr_addr_o), 32'h18);
        chk("burst_len_frozen", 32'(wr_burst_len_o), 32'd8);
        burst(8, 24'h18, 1'b0, 24'h0);
        chk("wrap_addr2", 32'(wr_addr_o), 32'h10);

        wr_end_addr_i = 24'h1000;
        burst(8, 24'h10, 1'b1, 24'h100);
        chk("load_mid_burst", 32'(wr_addr_o), 32'h100);

        init_end_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            user_wr_en_i   = 1'b1;
            user_wr_data_i = 16'(i);
            tick();
        end
        chk("fill_full", 32'(user_full_o), 32'd1);
        chk("fill_level", 32'(fifo_level_o), 32'(DEPTH));
        chk("fill_ovf_clear", 32'(overflow_o), 32'd0);
        user_wr_data_i = 16'hDEAD;
        tick();
        chk("ovf_set", 32'(overflow_o), 32'd1);
        chk("ovf_level", 32'(fifo_level_o), 32'(DEPTH));
        chk("ovf_head", 32'(wr_data_o), 32'd0);
        user_wr_data_i = 16'hBEEF;
        wr_ack_i       = 1'b1;
        tick();
        user_wr_en_i = 1'b0;
        wr_ack_i     = 1'b0;
        chk("full_pushpop_level", 32'(fifo_level_o), 32'(DEPTH));
        chk("full_pushpop_full", 32'(user_full_o), 32'd1);
        chk("full_pushpop_head", 32'(wr_data_o), 32'd1);

        init_end_i = 1'b1;
        tick();
        tick();
        chk("rst_burst_req", 32'(wr_en_o), 32'd1);
        wr_ack_i = 1'b1;
        tick();
        wr_ack_i = 1'b0;
        chk("rst_burst_in_burst", 32'(wr_en_o), 32'd0);
        sys_rst_n = 1'b0;
        #2;
        chk("midrst_wr_en", 32'(wr_en_o), 32'd0);
        chk("midrst_level", 32'(fifo_level_o), 32'd0);
        chk("midrst_full", 32'(user_full_o), 32'd0);
        chk("midrst_ovf", 32'(overflow_o), 32'd0);
        chk("midrst_unf", 32'(underflow_o), 32'd0);
        chk("midrst_addr", 32'(wr_addr_o), 32'd0);
        tick();
        sys_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("postrst_idle%0d", i), 32'(wr_en_o), 32'd0);
        end

        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        wr_base_addr_i = 24'h200;
        wr_end_addr_i  = 24'h260;
        cur_len  = 10'($urandom_range(1, 12));
        wr_burst_len_i = cur_len;
        wr_addr_load_i = 1'b1;
        tick();
        wr_addr_load_i = 1'b0;
        exp_addr = 24'h200;
        cs    = 0;
        rem   = 0;
        acked = 0;
        waitc = 0;
        blen  = cur_len;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            p = 1'($urandom % 2);
            d = 16'($urandom);
            a = (cs == 1) && (rem > 0) && ($urandom % 4 != 0);
            user_wr_en_i   = p;
            user_wr_data_i = d;
            wr_ack_i       = a;
            wr_end_i       = (cs == 2);
            tick();

            full = (q.size() == DEPTH);
            pp   = a && (q.size() != 0);
            if (p && full && !pp)
                m_ovf = 1'b1;
            if (a && q.size() == 0)
                m_unf = 1'b1;
            if (pp)
                void'(q.pop_front());
            if (p && (!full || pp))
                q.push_back(d);

            if (a) begin
                rem--;
                acked++;
            end
            if (cs == 2) begin
                s = exp_addr + {14'd0, blen};
                exp_addr = (s >= wr_end_addr_i) ? wr_base_addr_i : s;
                cur_len  = 10'($urandom_range(1, 12));
                wr_burst_len_i = cur_len;
                wr_end_i = 1'b0;
                cs = 0;
                waitc = 0;
            end else if (cs == 1) begin
                chk("rnd_wr_en_phase", 32'(wr_en_o), 32'(acked == 0));
                if (rem == 0)
                    cs = 2;
            end else if (wr_en_o) begin
                chk("rnd_req_addr", 32'(wr_addr_o), 32'(exp_addr));
                chk("rnd_req_len", 32'(wr_burst_len_o), 32'(cur_len));
                chk("rnd_launch_level", 32'(q.size() >= int'(cur_len)), 32'd1);
                blen  = cur_len;
                cs    = 1;
                rem   = int'(cur_len);
                acked = 0;
            end else if (q.size() >= int'(cur_len)) begin
                waitc++;
                if (waitc > 6) begin
                    chk("rnd_req_timeout", 32'd0, 32'd1);
                    waitc = 0;
                end
            end

            chk("rnd_level", 32'(fifo_level_o), 32'(q.size()));
            chk("rnd_full", 32'(user_full_o), 32'(q.size() == DEPTH));
            chk("rnd_ovf", 32'(overflow_o), 32'(m_ovf));
            chk("rnd_unf", 32'(underflow_o), 32'(m_unf));
            if (q.size() != 0)
                chk("rnd_head", 32'(wr_data_o), 32'(q[0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
